// File: rtl/polar_llr_pkg.sv
// Shared types and constants for the polar SC decoder LLR datapath.
package polar_llr_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int LLR_MAX        = 2 ** (DEF_DATA_WIDTH - 1) - 1;
  localparam int LLR_MIN        = -LLR_MAX;

  typedef logic signed [DEF_DATA_WIDTH-1:0] llr_t;

  typedef enum logic {
    OP_F = 1'b0,
    OP_G = 1'b1
  } fg_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } sched_state_e;

endpackage

// File: rtl/llr_fg_pe.sv
// Combinational f (min-sum) / g processing element for SC polar decoding.
// Define LLR_SAT_EN for symmetric saturation; otherwise results wrap in two's complement.
module llr_fg_pe
  import polar_llr_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                         op,
  input  logic                         u,
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  output logic signed [DATA_WIDTH-1:0] res
);

`ifdef LLR_SAT_EN
  localparam logic [DATA_WIDTH-1:0]        MAG_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH:0]   SUM_MAX = {2'b00, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH:0]   SUM_MIN = -SUM_MAX;
`endif

  logic [DATA_WIDTH-1:0]        mag_a;
  logic [DATA_WIDTH-1:0]        mag_b;
  logic [DATA_WIDTH-1:0]        mag_min;
  logic                         neg;
  logic signed [DATA_WIDTH:0]   a_x;
  logic signed [DATA_WIDTH:0]   b_x;
  logic signed [DATA_WIDTH:0]   sum;

  always_comb begin
    // Magnitudes are compared unsigned so the wrapped |min| (MSB set) ranks as the largest.
    mag_a = a[DATA_WIDTH-1] ? (~a + 1'b1) : a;
    mag_b = b[DATA_WIDTH-1] ? (~b + 1'b1) : b;
`ifdef LLR_SAT_EN
    if (mag_a[DATA_WIDTH-1]) mag_a = MAG_MAX;
    if (mag_b[DATA_WIDTH-1]) mag_b = MAG_MAX;
`endif
    mag_min = (mag_a < mag_b) ? mag_a : mag_b;
    neg     = a[DATA_WIDTH-1] ^ b[DATA_WIDTH-1];

    a_x = a;
    b_x = b;
    sum = u ? (b_x - a_x) : (b_x + a_x);

    res = '0;
    if (op == OP_F) begin
      res = neg ? (~mag_min + 1'b1) : mag_min;
    end else begin
`ifdef LLR_SAT_EN
      if (sum > SUM_MAX)      res = SUM_MAX[DATA_WIDTH-1:0];
      else if (sum < SUM_MIN) res = SUM_MIN[DATA_WIDTH-1:0];
      else                    res = sum[DATA_WIDTH-1:0];
`else
      res = sum[DATA_WIDTH-1:0];
`endif
    end
  end

endmodule

// File: rtl/llr_fg_sched.sv
// One-stage f/g sequencer: walks the LLR RAM, runs a 3-stage read/PE/write pipeline.
// Saturating arithmetic in the PE is selected with LLR_SAT_EN.
module llr_fg_sched
  import polar_llr_pkg::*;
#(
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int N_LOG      = 10,
  parameter  int ADDR_W     = N_LOG + 1,
  localparam int LEN_W      = $clog2(N_LOG)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_op,
  input  logic [LEN_W-1:0]      cmd_len_log,
  input  logic [ADDR_W-1:0]     cmd_src_base,
  input  logic [ADDR_W-1:0]     cmd_dst_base,
  input  logic [N_LOG-1:0]      cmd_ps_base,
  output logic                  rd_en,
  output logic [ADDR_W-1:0]     rd_addr_a,
  output logic [ADDR_W-1:0]     rd_addr_b,
  input  logic [DATA_WIDTH-1:0] rd_data_a,
  input  logic [DATA_WIDTH-1:0] rd_data_b,
  output logic [N_LOG-1:0]      ps_addr,
  input  logic                  ps_bit,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy,
  output logic                  done
);

  sched_state_e          state_q, state_d;
  fg_op_e                op_q, op_d;
  logic [N_LOG-1:0]      len_q, len_d;
  logic [N_LOG-1:0]      i_q, i_d;
  logic [ADDR_W-1:0]     src_q, src_d;
  logic [ADDR_W-1:0]     dst_q, dst_d;
  logic [N_LOG-1:0]      ps_base_q, ps_base_d;
  logic                  s1_valid_q, s1_valid_d;
  logic [N_LOG-1:0]      s1_idx_q, s1_idx_d;
  logic                  s1_last_q, s1_last_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  done_q, done_d;
  logic                  idle_ready;
  logic                  is_last;
  logic [DATA_WIDTH-1:0] pe_res;

  llr_fg_pe #(.DATA_WIDTH(DATA_WIDTH)) u_pe (
    .op  (op_q),
    .u   (ps_bit),
    .a   (rd_data_a),
    .b   (rd_data_b),
    .res (pe_res)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    len_d      = len_q;
    i_d        = i_q;
    src_d      = src_q;
    dst_d      = dst_q;
    ps_base_d  = ps_base_q;
    s1_valid_d = 1'b0;
    s1_idx_d   = s1_idx_q;
    s1_last_d  = 1'b0;
    wr_en_d    = s1_valid_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    done_d     = s1_valid_q & s1_last_q;
    idle_ready = 1'b0;
    busy       = 1'b0;
    rd_en      = 1'b0;
    is_last    = (i_q == (len_q - 1'b1));

    if (s1_valid_q) begin
      wr_addr_d = dst_q + ADDR_W'(s1_idx_q);
      wr_data_d = pe_res;
    end

    case (state_q)
      ST_IDLE: begin
        idle_ready = 1'b1;
        if (cmd_valid) begin
          op_d      = fg_op_e'(cmd_op);
          len_d     = N_LOG'(1) << cmd_len_log;
          src_d     = cmd_src_base;
          dst_d     = cmd_dst_base;
          ps_base_d = cmd_ps_base;
          i_d       = '0;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        busy       = 1'b1;
        rd_en      = 1'b1;
        s1_valid_d = 1'b1;
        s1_idx_d   = i_q;
        s1_last_d  = is_last;
        if (is_last) state_d = ST_DRAIN;
        else         i_d     = i_q + 1'b1;
      end
      ST_DRAIN: begin
        busy = 1'b1;
        // Leave only after the done cycle so cmd_ready rises one cycle later.
        if (done_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cmd_ready = idle_ready & rst_n;
  assign rd_addr_a = src_q + ADDR_W'(i_q);
  assign rd_addr_b = src_q + ADDR_W'(len_q) + ADDR_W'(i_q);
  assign ps_addr   = ps_base_q + i_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign done      = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_F;
      len_q      <= '0;
      i_q        <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      ps_base_q  <= '0;
      s1_valid_q <= 1'b0;
      s1_idx_q   <= '0;
      s1_last_q  <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      len_q      <= len_d;
      i_q        <= i_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      ps_base_q  <= ps_base_d;
      s1_valid_q <= s1_valid_d;
      s1_idx_q   <= s1_idx_d;
      s1_last_q  <= s1_last_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_llr_fg_sched.sv
// Directed bench for llr_fg_sched with a behavioural dual-read LLR RAM and partial-sum memory.
module tb_llr_fg_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_op = 1'b0;
  logic [3:0]  cmd_len_log = '0;
  logic [10:0] cmd_src_base = '0;
  logic [10:0] cmd_dst_base = '0;
  logic [9:0]  cmd_ps_base = '0;
  logic        rd_en;
  logic [10:0] rd_addr_a, rd_addr_b;
  logic [7:0]  rd_data_a = '0;
  logic [7:0]  rd_data_b = '0;
  logic [9:0]  ps_addr;
  logic        ps_bit = 1'b0;
  logic        wr_en;
  logic [10:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy, done;

  logic [7:0]  mem [0:2047];
  logic        psmem [0:1023];
  logic        ld_we = 1'b0;
  logic [10:0] ld_addr = '0;
  logic [7:0]  ld_data = '0;
  logic        ld_ps_we = 1'b0;
  logic [9:0]  ld_ps_addr = '0;
  logic        ld_ps_data = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  llr_fg_sched dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_len_log(cmd_len_log), .cmd_src_base(cmd_src_base),
    .cmd_dst_base(cmd_dst_base), .cmd_ps_base(cmd_ps_base),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .ps_addr(ps_addr), .ps_bit(ps_bit),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done)
  );

  // RAM model: one-cycle read latency, DUT write port plus a bench preload port.
  always @(posedge clk) begin
    if (rd_en) begin
      rd_data_a <= mem[rd_addr_a];
      rd_data_b <= mem[rd_addr_b];
      ps_bit    <= psmem[ps_addr];
    end
    if (wr_en) mem[wr_addr] <= wr_data;
    if (ld_we) mem[ld_addr] <= ld_data;
    if (ld_ps_we) psmem[ld_ps_addr] <= ld_ps_data;
  end

  task automatic checkOutput(input string tag, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic loadLlr(input int addr, input int val);
    @(negedge clk);
    ld_we = 1'b1; ld_addr = addr[10:0]; ld_data = val[7:0];
    @(posedge clk);
    #1 ld_we = 1'b0;
  endtask

  task automatic loadPs(input int addr, input int val);
    @(negedge clk);
    ld_ps_we = 1'b1; ld_ps_addr = addr[9:0]; ld_ps_data = val[0];
    @(posedge clk);
    #1 ld_ps_we = 1'b0;
  endtask

  task automatic applyStimulus(input int op, input int ll, input int src, input int dst, input int ps);
    int n = 0;
    @(negedge clk);
    cmd_op = op[0]; cmd_len_log = ll[3:0];
    cmd_src_base = src[10:0]; cmd_dst_base = dst[10:0]; cmd_ps_base = ps[9:0];
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("accept", cmd_ready, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Issues one command and checks read start, write slots, data, done and ready.
  task automatic runCmd(input int op, input int ll, input int src, input int dst, input int ps,
                        input int expd [8], input bit chk_data);
    int len = 1 << ll;
    int k = 0;
    int n = 0;
    bit seen_done = 1'b0;
    applyStimulus(op, ll, src, dst, ps);
    while (!seen_done && k < len + 20) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        checkOutput("rd_first", rd_en, 1);
        checkOutput("rd_addr_a0", rd_addr_a, src % 2048);
        checkOutput("rd_addr_b0", rd_addr_b, (src + len) % 2048);
      end
      if (wr_en) begin
        checkOutput("wr_slot", k, n + 3);
        checkOutput("wr_addr", wr_addr, (dst + n) % 2048);
        if (chk_data && n < 8) checkOutput("wr_data", int'($signed(wr_data)), expd[n]);
        checkOutput("done_pos", done, (n == len - 1) ? 1 : 0);
        n++;
      end
      if (done) seen_done = 1'b1;
    end
    checkOutput("done_seen", seen_done, 1);
    checkOutput("latency", k, len + 2);
    checkOutput("wr_count", n, len);
    @(negedge clk);
    checkOutput("ready_after", cmd_ready, 1);
    checkOutput("done_1cyc", done, 0);
  endtask

  initial begin
    int expd [8];
    int exp_a [8];
    int exp_b [8];
    int k, nw, first_done_k, second_done_k, acc_k;

    #2;
    checkOutput("rst_ready", cmd_ready, 0);
    checkOutput("rst_rd_en", rd_en, 0);
    checkOutput("rst_wr_en", wr_en, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);

    // f, L=1: min-sum of 5 and -3
    loadLlr(10, 5); loadLlr(11, -3);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_ready", cmd_ready, 1);
    checkOutput("idle_busy", busy, 0);
    expd = '{-3, 0, 0, 0, 0, 0, 0, 0};
    $display("[TB] f single element");
    runCmd(0, 0, 10, 100, 0, expd, 1'b1);

    // g, L=4 with alternating partial sums
    for (int i = 0; i < 4; i++) begin
      loadLlr(i, 5); loadLlr(4 + i, -3); loadPs(40 + i, i % 2);
    end
    expd = '{2, -8, 2, -8, 0, 0, 0, 0};
    $display("[TB] g length 4");
    runCmd(1, 2, 0, 16, 40, expd, 1'b1);

    // Most-negative and overflow corners
    loadLlr(20, -128); loadLlr(21, -128);
    loadLlr(30, 100); loadLlr(31, 100); loadPs(50, 0);
`ifdef LLR_SAT_EN
    expd = '{127, 0, 0, 0, 0, 0, 0, 0};
`else
    expd = '{-128, 0, 0, 0, 0, 0, 0, 0};
`endif
    $display("[TB] f saturation corner");
    runCmd(0, 0, 20, 120, 0, expd, 1'b1);
`ifdef LLR_SAT_EN
    expd = '{127, 0, 0, 0, 0, 0, 0, 0};
`else
    expd = '{-56, 0, 0, 0, 0, 0, 0, 0};
`endif
    $display("[TB] g saturation corner");
    runCmd(1, 0, 30, 130, 50, expd, 1'b1);

    // Back-to-back: g L=8 at src 64, then f L=8 at src 300, cmd_valid held
    exp_a = '{21, 18, 23, 16, 25, 14, 27, 12};
    exp_b = '{-4, -4, 2, 9, -60, -50, 0, -3};
    expd  = '{-7, 7, -2, 9, -100, 50, 0, 3};
    for (int i = 0; i < 8; i++) begin
      loadLlr(64 + i, i + 1); loadLlr(72 + i, 20); loadPs(i, i % 2);
      loadLlr(300 + i, expd[i]);
    end
    expd = '{4, -4, -6, 9, 60, -51, -5, -127};
    for (int i = 0; i < 8; i++) loadLlr(308 + i, expd[i]);
    $display("[TB] back-to-back commands");
    @(negedge clk);
    cmd_op = 1'b1; cmd_len_log = 4'd3; cmd_src_base = 11'd64; cmd_dst_base = 11'd200;
    cmd_ps_base = 10'd0; cmd_valid = 1'b1;
    checkOutput("b2b_ready", cmd_ready, 1);
    @(posedge clk);
    #1;
    cmd_op = 1'b0; cmd_src_base = 11'd300; cmd_dst_base = 11'd400;
    k = 0; nw = 0; first_done_k = 0; second_done_k = 0; acc_k = 0;
    while (second_done_k == 0 && k < 40) begin
      @(negedge clk);
      k++;
      if (wr_en) begin
        if (nw < 8) begin
          checkOutput("b2b_addr_a", wr_addr, 200 + nw);
          checkOutput("b2b_data_a", int'($signed(wr_data)), exp_a[nw]);
        end else if (nw < 16) begin
          checkOutput("b2b_addr_b", wr_addr, 400 + nw - 8);
          checkOutput("b2b_data_b", int'($signed(wr_data)), exp_b[nw - 8]);
        end
        nw++;
      end
      if (done && first_done_k == 0) first_done_k = k;
      else if (done) second_done_k = k;
      if (cmd_ready && acc_k == 0) begin
        acc_k = k;
        checkOutput("b2b_gap_wr", wr_en, 0);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
      end
    end
    checkOutput("b2b_first_done", first_done_k, 10);
    checkOutput("b2b_accept", acc_k, 11);
    checkOutput("b2b_second_done", second_done_k, 21);
    checkOutput("b2b_writes", nw, 16);

    // Reset mid-command, then rerun the same command
    for (int i = 0; i < 8; i++) begin
      loadLlr(500 + i, -3 * (i + 1)); loadLlr(508 + i, 40); loadPs(8 + i, 1);
    end
    $display("[TB] reset during command");
    applyStimulus(1, 3, 500, 600, 8);
    k = 0; nw = 0;
    while (nw < 3 && k < 20) begin
      @(negedge clk);
      k++;
      if (wr_en) nw++;
    end
    checkOutput("pre_rst_writes", nw, 3);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("arst_wr_en", wr_en, 0);
    checkOutput("arst_done", done, 0);
    checkOutput("arst_rd_en", rd_en, 0);
    checkOutput("arst_busy", busy, 0);
    checkOutput("arst_ready", cmd_ready, 0);
    checkOutput("arst_wr_addr", wr_addr, 0);
    checkOutput("arst_wr_data", wr_data, 0);
    checkOutput("arst_rd_addr_a", rd_addr_a, 0);
    checkOutput("arst_rd_addr_b", rd_addr_b, 0);
    checkOutput("arst_ps_addr", ps_addr, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("post_rst_done", done, 0);
      checkOutput("post_rst_wr", wr_en, 0);
    end
    for (int i = 0; i < 8; i++) loadLlr(600 + i, 0);
    expd = '{43, 46, 49, 52, 55, 58, 61, 64};
    runCmd(1, 3, 500, 600, 8, expd, 1'b1);

    // Address walk over the upper half of the RAM
    $display("[TB] address walk L=512");
    applyStimulus(0, 9, 1024, 0, 0);
    for (int j = 0; j < 512; j++) begin
      @(negedge clk);
      checkOutput("walk_b", rd_addr_b, 1536 + j);
      if (j == 511) begin
        checkOutput("walk_last_a", rd_addr_a, 1535);
        checkOutput("walk_last_ps", ps_addr, 511);
        checkOutput("walk_last_rd", rd_en, 1);
      end
    end
    k = 0;
    while (!done && k < 10) begin
      @(negedge clk);
      k++;
    end
    checkOutput("walk_done", done, 1);
    checkOutput("walk_tail", k, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/llr_fg_sched.md
Name: llr_fg_sched

Overview:
- Sequencer for one stage of the successive-cancellation polar decoder.
- Accepts a stage command (f or g, length, base addresses) and walks the LLR RAM one element per cycle.
- Feeds operand pairs through a single f/g processing element and writes results back to the LLR RAM.
- Sits between the SC tree controller (command source) and the dual-read/single-write LLR RAM and partial-sum memory.

Parameters:
- DATA_WIDTH, 8, signed LLR width in two's complement.
- N_LOG, 10, log2 of code length N.
- ADDR_W, N_LOG+1, LLR RAM address width (RAM holds 2N LLRs).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  1  0 = f (min-sum), 1 = g.
- cmd_len_log  in  $clog2(N_LOG)  log2 of output count L; legal range 0..N_LOG-1.
- cmd_src_base  in  ADDR_W  base address of the 2L input LLRs.
- cmd_dst_base  in  ADDR_W  base address of the L output LLRs.
- cmd_ps_base  in  N_LOG  base address of partial-sum bits (used only for g).
- rd_en  out  1  read strobe to both RAM read ports.
- rd_addr_a  out  ADDR_W  address of alpha[i].
- rd_addr_b  out  ADDR_W  address of alpha[i+L].
- rd_data_a  in  DATA_WIDTH  data for rd_addr_a, valid 1 cycle after rd_en.
- rd_data_b  in  DATA_WIDTH  data for rd_addr_b, valid 1 cycle after rd_en.
- ps_addr  out  N_LOG  partial-sum address, issued with rd_en.
- ps_bit  in  1  partial sum u[i], valid 1 cycle after rd_en.
- wr_en  out  1  write strobe.
- wr_addr  out  ADDR_W  result address.
- wr_data  out  DATA_WIDTH  result LLR.
- busy  out  1  a command is in flight.
- done  out  1  one-cycle pulse, coincident with the last wr_en of a command.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, index counter 0, pipeline valids cleared. Reset mid-command aborts it; pending writes are dropped and no done is issued.
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE: cmd_ready=1, busy=0. On cmd_valid, latch all cmd_* fields, set L = 1<<cmd_len_log, i=0, go to ISSUE.
- ISSUE: busy=1, cmd_ready=0. Each cycle drive rd_en=1, rd_addr_a=src+i, rd_addr_b=src+L+i, ps_addr=ps_base+i; then i++. When i==L-1, issue the final read and go to DRAIN.
- DRAIN: hold until the last result is written, then return to IDLE. cmd_ready rises the cycle after done.
- Pipeline, 3 stages:
  - Stage 0: issue read.
  - Stage 1: RAM data and ps_bit arrive; PE result is computed combinationally and registered together with wr_addr=dst+i.
  - Stage 2: wr_en=1 with that registered result.
- Timing: wr_en for element i occurs 2 cycles after its rd_en. A command occupies L+2 cycles from acceptance to done; done is asserted with wr_en of element L-1.
- f: sign = sign(a) XOR sign(b); magnitude = min(|a|,|b|); result = sign ? -mag : mag. a = rd_data_a, b = rd_data_b.
- g: result = b + a when u=0, b - a when u=1. The sum is computed at DATA_WIDTH+1 bits, then reduced (see LLR_SAT_EN).
- Length edge: cmd_len_log=0 → single read, done at acceptance+2.
- cmd_op is ignored for ps_addr; ps_addr is still driven in f mode.
- cmd_valid during busy is not accepted and must be held by the source.
- Address arithmetic wraps modulo 2^ADDR_W; the command source guarantees ranges do not overlap.

Optional Feature:
- Macro: LLR_SAT_EN.
- Defined: |x| of the most-negative value saturates to 2^(DATA_WIDTH-1)-1. g results clamp to [-(2^(DATA_WIDTH-1)-1), +(2^(DATA_WIDTH-1)-1)], a symmetric range.
- Undefined: plain two's-complement wrap on both operations (the most-negative value negates to itself; g truncates to DATA_WIDTH).

Decomposition:
- Package polar_llr_pkg holds:
  - DATA_WIDTH default and LLR_MAX/LLR_MIN constants.
  - typedef enum logic {OP_F, OP_G} fg_op_e.
  - typedef enum for the FSM states.
  - typedef llr_t (signed DATA_WIDTH).
- Sub-module llr_fg_pe: purely combinational f/g unit with the saturation option, instantiated once in stage 1.

Test Plan:
- f, len_log=0, a=5, b=-3 → wr_data=-3 two cycles after rd_en; done with that write; cmd_ready high the next cycle.
- g, len_log=2, src=0, dst=16, a={5,5,5,5}, b={-3,-3,-3,-3}, u={0,1,0,1} → wr 16..19 = {2,-8,2,-8}; 4 consecutive wr_en; done on the 4th.
- Saturation, f with a=b=-128 and g with a=b=100, u=0 → LLR_SAT_EN: +127, +127; without it: -128, -56.
- Back-to-back: cmd_valid held high with two len_log=3 commands → second accepted exactly one cycle after first done; no overlap of wr_en streams; total 2×10+1 cycles.
- Reset pulse after 3 writes of a len_log=3 command → all outputs 0 asynchronously, no done; a subsequent command completes all 8 writes correctly.
- Address walk, len_log=9, src=1024 → rd_addr_b = 1536+i, i=0..511; last rd_addr_a=1535.
